// File: rtl/data_mem_access_unit.sv
// Multi-cycle load/store unit: req/ack data bus, lane steering, load extension, stall.
// Optional BUS_TIMEOUT_EN adds a wait-state timeout with a sticky bus_error flag.
module data_mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [ADDR_WIDTH-1:0] aluout,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_be,
`ifdef BUS_TIMEOUT_EN
    output logic                  bus_error,
`endif
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_req;
    logic                  r_we;
    logic                  r_uns;
    logic [1:0]            r_size;
    logic [1:0]            r_lo;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [31:0]           r_rdata;

    logic                  w_access;
    logic                  w_timeout;
    logic                  w_finish;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_lane;
    logic [31:0]           w_load;

    assign misaligned = ((mem_size == 2'b01) & aluout[0])
                      | (mem_size[1] & (aluout[1:0] != 2'b00));
    assign w_access   = (mem_read | mem_write) & ~misaligned;
    assign w_finish   = (r_state == S_WAIT) & (bus_ack | w_timeout);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = writeData;
        case (mem_size)
            2'b00: begin
                w_be    = 4'b0001 << aluout[1:0];
                w_wdata = {4{writeData[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << aluout[1:0];
                w_wdata = {2{writeData[15:0]}};
            end
            default: ;
        endcase
    end

    // Word accesses are aligned, so r_lo is 0 and the shifted lane is the whole word.
    assign w_lane = bus_rdata >> {r_lo, 3'b000};

    always_comb begin
        w_load = w_lane;
        case (r_size)
            2'b00:   w_load = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
            default: ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] LP_TO = 16'(TIMEOUT_CYCLES);
    logic [15:0] r_cnt;
    logic        r_err;

    assign w_timeout = (r_state == S_WAIT) & ~bus_ack
                     & ((r_cnt + 16'd1) >= LP_TO);
    assign bus_error = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != S_WAIT)
                r_cnt <= '0;
            else if (!bus_ack)
                r_cnt <= r_cnt + 16'd1;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_access) w_next = S_WAIT;
            S_WAIT:  if (bus_ack | w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall = ((r_state == S_IDLE) & w_access) | (r_state == S_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_lo    <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else if ((r_state == S_IDLE) && w_access) begin
            r_req   <= 1'b1;
            r_we    <= mem_write;
            r_uns   <= mem_unsigned;
            r_size  <= mem_size;
            r_lo    <= aluout[1:0];
            r_addr  <= {aluout[ADDR_WIDTH-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
        end else if (w_finish) begin
            r_req <= 1'b0;
            if (!r_we)
                r_rdata <= bus_ack ? w_load : 32'd0;
        end
    end

    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_be    = r_be;
    assign readData  = r_rdata;

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Multi-cycle load/store unit directly downstream of the single-cycle MIPS datapath.
- Consumes the datapath's ALU result (as the address) and its register read-port-2 value (as store data), and drives a request/acknowledge data bus.
- Returns the aligned, extended load value as readData to the datapath's write-back mux.
- Holds the processor with a stall signal while a bus transaction is in flight.

Parameters:
- ADDR_WIDTH, 32: width of aluout and bus_addr.
- TIMEOUT_CYCLES, 255: wait cycles before a bus timeout abort (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mem_read  input  1  load request from control
- mem_write  input  1  store request from control
- mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads
- aluout  input  ADDR_WIDTH  effective byte address
- writeData  input  32  store data, right-justified
- readData  output  32  extended load result to write-back
- stall  output  1  freeze PC and register write while high
- misaligned  output  1  combinational flag: half access with addr[0]=1, or word access with addr[1:0]!=0
- bus_req  output  1  bus request
- bus_we  output  1  1 = write cycle
- bus_addr  output  ADDR_WIDTH  word-aligned address: {aluout[ADDR_WIDTH-1:2], 2'b00}
- bus_wdata  output  32  store data replicated across lanes
- bus_be  output  4  byte enables, little-endian
- bus_rdata  input  32  read data, valid when bus_ack is high
- bus_ack  input  1  one-cycle transfer completion
- bus_error  output  1  timeout flag (present only with BUS_TIMEOUT_EN)

Behaviour:
- Reset:
  - Asserting reset (low) is asynchronous: state goes to IDLE.
  - bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, readData=0, bus_error=0.
  - Reset mid-transaction drops bus_req immediately; a pending bus_ack is ignored.
- Access request: access = (mem_read | mem_write) & ~misaligned.
  - If both mem_read and mem_write are high, the access is a write.
- stall, combinational: (state==IDLE & access) | (state==WAIT). It is 0 in DONE.
- Misaligned request:
  - No bus cycle is issued and stall stays 0.
  - misaligned=1 for the cycle.
  - For loads, readData keeps its previous value.
- States:
  - IDLE:
    - On access, at the clock edge: register bus_addr, bus_we, bus_be and bus_wdata, set bus_req=1, and go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - Hold all bus outputs stable.
    - When bus_ack=1 is sampled: clear bus_req.
    - If the access is a read, also latch the extended bus_rdata into readData.
    - Then go to DONE.
  - DONE:
    - Lasts one cycle; stall=0, so the instruction retires with a valid readData.
    - Always returns to IDLE.
    - Never re-issues, even though mem_read/mem_write are still high.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0] (addr[1:0] is 00 or 10)
  - word: 1111
- Write data:
  - byte: {4{writeData[7:0]}}
  - half: {2{writeData[15:0]}}
  - word: writeData
- Load extraction:
  - byte: lane addr[1:0]
  - half: lane addr[1]
  - Result is sign- or zero-extended to 32 bits according to mem_unsigned.
- Total latency: an access with a bus_ack N cycles after bus_req rises stalls for N+1 cycles.
  - Zero-wait bus (bus_ack in the first WAIT cycle) gives stall high for 2 cycles (IDLE request cycle and WAIT), then DONE.
- bus_ack is ignored in IDLE and DONE.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter is cleared on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop bus_req, set readData=0 for loads, set bus_error=1, and go to DONE.
  - bus_error is sticky until reset.
  - If ack and timeout occur in the same cycle, ack wins.
- Undefined:
  - No counter and no bus_error port.
  - WAIT persists indefinitely until ack.

Test Plan:
- Zero-wait word load:
  - Stimulus: mem_read=1, mem_size=10, aluout=0x0000_0104, bus_rdata=0xDEAD_BEEF with ack in the first WAIT cycle.
  - Response: bus_addr=0x104, bus_be=1111, stall high for 2 cycles, readData=0xDEAD_BEEF in DONE.
- Signed byte load with 3 wait states:
  - Stimulus: aluout=0x0000_0203, mem_size=00, mem_unsigned=0, bus_rdata=0x80xx_xxxx, ack after 3 WAIT cycles.
  - Response: bus_be=1000, readData=0xFFFF_FF80, stall high for 5 cycles.
- Half store:
  - Stimulus: mem_write=1, mem_size=01, aluout=0x0000_0012, writeData=0x1234_ABCD.
  - Response: bus_we=1, bus_addr=0x10, bus_be=1100, bus_wdata=0xABCD_ABCD.
- Misaligned word load:
  - Stimulus: aluout=0x0000_0006, mem_size=10.
  - Response: misaligned=1, bus_req stays 0, stall=0, readData unchanged.
- Reset mid-transaction:
  - Stimulus: reset pulled low during WAIT; ack arrives after release.
  - Response: bus_req=0 immediately, state IDLE, readData=0, no latch from the late ack.
- Timeout (BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4):
  - Stimulus: load with no ack.
  - Response: bus_req drops after 4 WAIT cycles, bus_error=1, readData=0, DONE reached.
